// File: rtl/tsb_pkg.sv
// Shared types and constants for the tri-state bus arbiter: state encoding,
// parameter limits and a saturating counter helper.
package tsb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_DRIVE = DRIVE,
    S_TURN  = TURN
  } tsb_state_e;

  localparam int MAX_CH   = 8;
  localparam int MAX_TURN = 7;
  localparam int HOLD_W   = 8;
  localparam int TURN_W   = 3;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: scans req starting at rr_ptr,
// wrapping modulo NUM_CH, and reports the first requesting channel.
module rr_pick
  import tsb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic              found,
  output logic [IW-1:0]     winner
);

  int            idx;
  logic [IW-1:0] sel;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin tri-state bus driver with turnaround gap and bounded ownership.
// Optional bus keeper enabled by defining TRISTATE_BUS_KEEPER_EN.
module tristate_bus_arbiter
  import tsb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_CH     = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] din,
  output logic [NUM_CH-1:0]       gnt,
  inout  wire  [WIDTH-1:0]        bus,
  output logic [WIDTH-1:0]        bus_in,
  output logic                    busy
);

  localparam int                IW        = $clog2(NUM_CH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND - 1);
  localparam logic [IW:0]       NUM_CH_W  = (IW+1)'(NUM_CH);

  tsb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;

  logic                found;
  logic [IW-1:0]       winner;
  logic [NUM_CH-1:0]   owner_oh;
  logic [NUM_CH-1:0]   winner_oh;
  logic                other_req;
  logic [IW:0]         ptr_inc;
  logic                drv_en;
  logic [WIDTH-1:0]    drv_data;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .winner (winner)
  );

  assign owner_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << owner_q;
  assign winner_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
  assign other_req = |(req & ~owner_oh);
  assign ptr_inc   = {1'b0, owner_q} + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = gnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_DRIVE;
          gnt_d      = winner_oh;
          owner_d    = winner;
          hold_cnt_d = '0;
        end
      end
      S_DRIVE: begin
        hold_cnt_d = sat_inc(hold_cnt_q);
        // Pre-emption only fires on the exact MAX_HOLD boundary cycle.
        if (!req[owner_q] || ((hold_cnt_q == HOLD_LAST) && other_req)) begin
          state_d    = S_TURN;
          gnt_d      = '0;
          rr_ptr_d   = (ptr_inc == NUM_CH_W) ? '0 : ptr_inc[IW-1:0];
          turn_cnt_d = TURN_LOAD;
        end
      end
      S_TURN: begin
        if (turn_cnt_q != '0) begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end else if (found) begin
          state_d    = S_DRIVE;
          gnt_d      = winner_oh;
          owner_d    = winner;
          hold_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign drv_en   = |gnt_q;
  assign drv_data = din[int'(owner_q)*WIDTH +: WIDTH];

  // Enable is taken from the registered grant so it drops with async reset.
  for (genvar b = 0; b < WIDTH; b++) begin : g_drv
    assign bus[b] = drv_en ? drv_data[b] : 1'bz;
  end

`ifdef TRISTATE_BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q, keep_d;

  always_comb begin
    keep_d = keep_q;
    if (state_q == S_DRIVE) begin
      keep_d = drv_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign bus_in = drv_en ? bus : keep_q;
`else
  assign bus_in = bus;
`endif

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Randomized self-checking bench for tristate_bus_arbiter against an
// ownership/gap model; a probe driver observes the bus while it should be free.
module tb_tristate_bus_arbiter;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int TA    = 2;
  localparam int MH    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] din;
  logic [NCH-1:0]       gnt;
  wire  [WIDTH-1:0]     bus;
  logic [WIDTH-1:0]     bus_in;
  logic                 busy;
  logic                 probe_en;
  logic [WIDTH-1:0]     probe_val;

  int n_tests = 0;
  int n_fail  = 0;

  // model: current owner (-1 none), cycles held, idle gap cycles left, priority pointer
  int               m_owner, m_held, m_gap, m_ptr;
  logic [WIDTH-1:0] m_keep;

  assign bus = probe_en ? probe_val : 'z;

  tristate_bus_arbiter #(
    .WIDTH      (WIDTH),
    .NUM_CH     (NCH),
    .TURNAROUND (TA),
    .MAX_HOLD   (MH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .bus    (bus),
    .bus_in (bus_in),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] r, input int p);
    for (int k = 0; k < NCH; k++) begin
      if (r[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_keep  = '0;
  endtask

  task automatic model_step();
    int  w;
    logic others;
    if (m_owner >= 0) begin
      m_keep = din[m_owner*WIDTH +: WIDTH];
      m_held++;
      others = (req & ~(4'b0001 << m_owner)) != 0;
      if (!req[m_owner] || (m_held == MH && others)) begin
        m_ptr   = (m_owner + 1) % NCH;
        m_owner = -1;
        m_gap   = TA;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      w     = pick(req, m_ptr);
      m_gap = 0;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 0;
      end
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] exp_gnt;
    @(posedge clk);
    model_step();
    #1;
    if (m_owner < 0 && $urandom_range(1, 0) == 1) begin
      probe_val = $urandom;
      probe_en  = 1'b1;
    end
    @(negedge clk);
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", gnt, exp_gnt);
    check("busy", busy, (m_owner >= 0 || m_gap > 0));
    check("onehot", ($countones(gnt) <= 1), 1'b1);
    if (m_owner >= 0) begin
      check("bus", bus, din[m_owner*WIDTH +: WIDTH]);
      check("bus_in", bus_in, din[m_owner*WIDTH +: WIDTH]);
    end else begin
`ifdef TRISTATE_BUS_KEEPER_EN
      check("keeper", bus_in, m_keep);
`endif
      if (probe_en) begin
        check("bus_free", bus, probe_val);
`ifndef TRISTATE_BUS_KEEPER_EN
        check("bus_in_free", bus_in, probe_val);
`endif
      end
    end
    probe_en = 1'b0;
  endtask

  task automatic do_reset(input logic [NCH-1:0] r);
    req      = r;
    rst_n    = 1'b0;
    probe_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    probe_val = $urandom;
    probe_en  = 1'b1;
    #1;
    check("rst_bus_free", bus, probe_val);
    probe_en = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int gap_cnt;
    int hog_bad;
    logic [NCH-1:0] prev;

    exp_order = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req       = '0;
    probe_en  = 1'b0;
    probe_val = '0;
    din       = {$urandom, $urandom, $urandom, $urandom};

    // reset with all requesting, then round-robin with pre-emption
    do_reset(4'b1111);
    prev = '0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (gnt != 0 && gnt != prev) begin
        for (int c = 0; c < NCH; c++) if (gnt[c]) order.push_back(c);
      end
      prev = gnt;
    end
    check("fair_count", (order.size() >= 5), 1'b1);
    for (int k = 0; k < 5 && k < order.size(); k++) check("fair_order", order[k], exp_order[k]);

    // handover ch0 -> ch2 with turnaround gap
    do_reset(4'b0000);
    din[0*WIDTH +: WIDTH] = 32'hA5A5_0000;
    din[2*WIDTH +: WIDTH] = 32'h0000_5A5A;
    req = 4'b0101;
    repeat (3) cycle();
    req     = 4'b0100;
    gap_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (gnt == 0) gap_cnt++;
    end
    check("handover_gap", gap_cnt, TA);
    check("handover_owner", gnt, 4'b0100);

    // single requester: no pre-emption, no gap
    req     = 4'b1000;
    hog_bad = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (i >= 10 && gnt != 4'b1000) hog_bad++;
    end
    check("hog_gaps", hog_bad, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int b;
      if ($urandom_range(3, 0) == 0) begin
        b      = $urandom_range(NCH - 1, 0);
        req[b] = ~req[b];
      end
      din = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    // async reset in the middle of a drive
    req = 4'b0010;
    for (int i = 0; i < 20 && m_owner != 1; i++) cycle();
    check("arst_grant", gnt, 4'b0010);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    probe_val = $urandom;
    probe_en  = 1'b1;
    #1;
    check("arst_gnt", gnt, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_bus_free", bus, probe_val);
`ifdef TRISTATE_BUS_KEEPER_EN
    check("arst_keeper", bus_in, '0);
`endif
    probe_en = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Parametrised multi-channel tri-state bus driver with round-robin arbitration, a guaranteed turnaround gap and bounded ownership. It sits between several on-chip masters (core load/store path, DMA, debug port) and a shared bidirectional data bus of the SimpleRISC SoC. Only one channel's enable ever reaches the pad-side tri-state driver at a time, and a dead cycle is inserted between drivers so the bus never sees contention.

## Interface
- `WIDTH`, 32: bus data width in bits.
- `NUM_CH`, 4: number of requesting channels, 2..8.
- `TURNAROUND`, 1: idle cycles with no driver between ownership changes, 1..7.
- `MAX_HOLD`, 16: maximum consecutive DRIVE cycles while another channel is requesting, 1..255.

Ports:
- `clk`  in  1  single clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_CH  per-channel bus request, level-sensitive.
- `din`  in  NUM_CH*WIDTH  flattened write data; channel i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  NUM_CH  one-hot grant, registered.
- `bus`  inout  WIDTH  shared tri-state bus.
- `bus_in`  out  WIDTH  value observed on `bus`, for readers.
- `busy`  out  1  high in DRIVE or TURN.

## Operation
- States: IDLE, DRIVE, TURN. Registers: `owner` (index), `rr_ptr` (next-highest-priority index), `hold_cnt` (8 bits), `turn_cnt` (3 bits).
- Arbitration: search `req` starting at `rr_ptr`, wrapping modulo NUM_CH. The first set bit wins.
- IDLE: if any `req` is set, go to DRIVE, set `gnt` one-hot at the winner, `owner` = winner, `hold_cnt` = 0.
- DRIVE:
  - Each cycle `hold_cnt` increments, saturating at 255.
  - Leave DRIVE when `req[owner]` = 0, or when `hold_cnt` = MAX_HOLD-1 and some other `req` bit is set.
  - On leaving: go to TURN, `gnt` = 0, `rr_ptr` = (owner+1) mod NUM_CH, `turn_cnt` = TURNAROUND-1.
- TURN:
  - If `turn_cnt` != 0, decrement it.
  - If `turn_cnt` = 0, arbitrate as in IDLE. With a winner, go straight to DRIVE; otherwise go to IDLE.
- Bus drive: `bus` = `din[owner]` whenever `gnt` != 0, else high-Z (all bits). The enable comes from the registered `gnt`; the data path is combinational from `din`.
- `bus_in` = `bus` (continuous).
- `busy` = (state != IDLE).
- The `gnt` one-hot invariant holds always: zero or one bit set, never more.

## Timing
- Reset (async assert, sync release): state IDLE, `gnt` = 0, `bus` high-Z, `busy` = 0, `rr_ptr` = 0, counters 0.
- Latency:
  - `req` rises in IDLE at edge N → `gnt` and bus drive from edge N+1.
  - Owner drops `req` at edge N → `gnt` low from edge N+1. The next owner drives at edge N+1+TURNAROUND.
- Grant persistence: a granted channel sees `gnt` held until it releases `req` or is pre-empted by MAX_HOLD. It must keep `din` valid while `gnt` is high.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. A loser keeps `req` high and is served next.
- Single requester: no pre-emption. `hold_cnt` saturates and ownership continues indefinitely.
- A `req` pulse that drops before being granted is ignored, with no memory of it.
- Reset mid-DRIVE: `gnt` and the bus enable drop asynchronously; the bus is high-Z in the same instant.

## Configuration
- `TRISTATE_BUS_KEEPER_EN`
- Defined: add a WIDTH-bit keeper register, loaded with `din[owner]` every DRIVE cycle and reset to 0. `bus_in` returns the keeper value when `gnt` = 0, so readers never sample Z/X during TURN or IDLE.
- Undefined: no keeper register. `bus_in` follows `bus` and is Z when undriven.

## Structure
- Shared package `tsb_pkg`:
  - State encoding localparams: IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2.
  - Limit constants MAX_CH = 8, MAX_TURN = 7.
- Sub-module `rr_pick`: combinational round-robin first-set finder. Inputs are `req` and `rr_ptr`; outputs are a `found` flag and the winner index. It is instantiated once.
- The per-bit tri-state driver is a generate loop of `assign` statements, not instantiated cells.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'b1111 → `gnt` = 0, `bus` all-Z, `busy` = 0. Release → `gnt` = 4'b0001 one cycle later.
- Handover: ch0 holds `req` for 5 cycles with `din[0]` = 32'hA5A5_0000, ch2 requests throughout with `din[2]` = 32'h0000_5A5A.
  - `bus` = A5A5_0000 for 5 cycles, then exactly TURNAROUND high-Z cycles, then 0000_5A5A.
  - Checker asserts no cycle with two grants.
- Fairness: all four request continuously, MAX_HOLD = 4 → grant order 0,1,2,3,0, each holding 4 cycles separated by TURN gaps.
- Solo hog: only ch3 requests for 300 cycles → `gnt` = 4'b1000 throughout, with no pre-emption and no gap.
- Async reset mid-DRIVE: assert `rst_n` low between edges → `bus` goes Z before the next clock edge and `gnt` = 0.
- Keeper (macro defined): ch1 drives 32'hDEAD_BEEF, then releases → `bus_in` reads DEAD_BEEF during TURN and IDLE. Without the macro, `bus_in` reads Z.
